// File: rtl/core_id_wb_arbiter.sv
// Generic FIFO for the load-response path: registered storage, occupancy count.
// Latency: an entry is visible at pop_dat the cycle after it is pushed.
// Backpressure: none internally; caller must not push when full or pop when empty.
module core_id_wb_arbiter_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];

    assign pop_dat = mem[rd_ptr];

    // Storage is left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end
endmodule

// Writeback arbiter: merges unstallable ALU results with buffered load responses onto one RF write port.
// Latency: winner appears on rf_write/waddr/data exactly 1 cycle after arbitration.
// Backpressure: mem_ready drops when the load FIFO is full; stall_req holds the ALU off to drain loads.
module core_id_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_waddr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     rf_write,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        data,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     protocol_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic [CW-1:0] count_nxt;
    logic          alu_cand;
    logic          push;
    logic          pop;
    wb_ent_t       push_ent;
    wb_ent_t       head_ent;

    // Full FIFO is never ready, even if the head pops this cycle.
    assign mem_ready = (fifo_count < CW'(DEPTH));

    // Register 0 writes are dropped; a load to r0 is still handshaken.
    assign alu_cand = alu_valid && (alu_waddr != '0);
    assign push     = mem_valid && mem_ready && (mem_waddr != '0);
    assign pop      = !alu_cand && (fifo_count != '0);

    assign push_ent = '{waddr: mem_waddr, data: mem_data};

    core_id_wb_arbiter_fifo #(
        .W     ($bits(wb_ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .pop_dat  (head_ent),
        .count    (fifo_count)
    );

    // Next occupancy and starvation count, used to steer the FSM at this edge.
    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - CW'(1);
        end
        wait_nxt = wait_cnt;
        if (pop || (fifo_count == '0)) begin
            wait_nxt = '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_nxt = wait_cnt + WW'(1);
        end
    end

    // Starvation counter: cycles the buffered head has been denied, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

    // Registered write port; address/data hold when there is no winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write <= 1'b0;
            waddr    <= '0;
            data     <= '0;
        end else begin
            rf_write <= alu_cand || pop;
            if (alu_cand) begin
                waddr <= alu_waddr;
                data  <= alu_data;
            end else if (pop) begin
                waddr <= head_ent.waddr;
                data  <= head_ent.data;
            end
        end
    end

    // Drain FSM: enter FLUSH when the FIFO fills or the head starves, leave once empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= NORMAL;
            stall_req <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if ((count_nxt == CW'(DEPTH)) || (wait_nxt == WW'(MAX_WAIT))) begin
                        state     <= FLUSH;
                        stall_req <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (count_nxt == '0) begin
                        state     <= NORMAL;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= NORMAL;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag: the pipeline issued an ALU result while told to stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            protocol_err <= 1'b0;
        end else if (alu_valid && stall_req) begin
            protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_id_wb_arbiter.sv
// Directed-vector bench for core_id_wb_arbiter.
// Inputs change on the falling edge; registered outputs are compared on the following falling edge.
// Expected values are hand-computed for DEPTH=4, MAX_WAIT=8.
module tb_core_id_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_data;
    logic        rf_write;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        stall_req;
    logic [2:0]  fifo_count;
    logic        protocol_err;

    core_id_wb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .DEPTH    (4),
        .MAX_WAIT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_waddr    (alu_waddr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_waddr    (mem_waddr),
        .mem_data     (mem_data),
        .rf_write     (rf_write),
        .waddr        (waddr),
        .data         (data),
        .stall_req    (stall_req),
        .fifo_count   (fifo_count),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aw;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mw;
        logic [31:0] md;
        logic        rfw;
        logic [4:0]  wa;
        logic [31:0] d;
        logic        st;
        logic [2:0]  cnt;
        logic        rdy;
        logic        perr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(logic av, logic [4:0] aw, logic [31:0] ad,
                                logic mv, logic [4:0] mw, logic [31:0] md,
                                logic rfw, logic [4:0] wa, logic [31:0] d,
                                logic st, logic [2:0] cnt, logic rdy, logic perr);
        vec_t v;
        v.av = av; v.aw = aw; v.ad = ad;
        v.mv = mv; v.mw = mw; v.md = md;
        v.rfw = rfw; v.wa = wa; v.d = d;
        v.st = st; v.cnt = cnt; v.rdy = rdy; v.perr = perr;
        return v;
    endfunction

    task automatic check(string name, logic rfw, logic [4:0] wa, logic [31:0] d,
                         logic st, logic [2:0] cnt, logic rdy, logic perr);
        n_vec++;
        if (rf_write !== rfw || waddr !== wa || data !== d || stall_req !== st ||
            fifo_count !== cnt || mem_ready !== rdy || protocol_err !== perr) begin
            n_bad++;
            $display("FAIL %s: got rfw=%b wa=%0d d=%h st=%b cnt=%0d rdy=%b perr=%b, want rfw=%b wa=%0d d=%h st=%b cnt=%0d rdy=%b perr=%b",
                     name, rf_write, waddr, data, stall_req, fifo_count, mem_ready, protocol_err,
                     rfw, wa, d, st, cnt, rdy, perr);
        end
    endtask

    task automatic drive(logic av, logic [4:0] aw, logic [31:0] ad,
                         logic mv, logic [4:0] mw, logic [31:0] md);
        alu_valid = av; alu_waddr = aw; alu_data = ad;
        mem_valid = mv; mem_waddr = mw; mem_data = md;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // ALU only, including an r0 write that must be dropped
        tbl.push_back(mk(1, 3, 32'h11,   0, 0, 0,         1, 3, 32'h11,   0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h22,   0, 0, 0,         0, 3, 32'h11,   0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         0, 3, 32'h11,   0, 0, 1, 0));
        // Load only: push, then pop on the next idle cycle
        tbl.push_back(mk(0, 0, 0,        1, 5, 32'hAAAA,  0, 3, 32'h11,   0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 5, 32'hAAAA, 0, 0, 1, 0));
        // Load to r0 is consumed but never queued
        tbl.push_back(mk(0, 0, 0,        1, 0, 32'hBBBB,  0, 5, 32'hAAAA, 0, 0, 1, 0));
        // Collision: ALU beats the queued head, head drains next idle cycle
        tbl.push_back(mk(0, 0, 0,        1, 9, 32'h2,     0, 5, 32'hAAAA, 0, 1, 1, 0));
        tbl.push_back(mk(1, 7, 32'h1,    0, 0, 0,         1, 7, 32'h1,    0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 9, 32'h2,    0, 0, 1, 0));
        // Fill while ALU busy: full -> not ready and stall
        tbl.push_back(mk(1, 1, 32'h10,   1, 10, 32'h100,  1, 1, 32'h10,   0, 1, 1, 0));
        tbl.push_back(mk(1, 2, 32'h20,   1, 11, 32'h101,  1, 2, 32'h20,   0, 2, 1, 0));
        tbl.push_back(mk(1, 3, 32'h30,   1, 12, 32'h102,  1, 3, 32'h30,   0, 3, 1, 0));
        tbl.push_back(mk(1, 4, 32'h40,   1, 13, 32'h103,  1, 4, 32'h40,   1, 4, 0, 0));
        // Drain in order; the load offered while full is refused
        tbl.push_back(mk(0, 0, 0,        1, 14, 32'h104,  1, 10, 32'h100, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 11, 32'h101, 1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 12, 32'h102, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 13, 32'h103, 0, 0, 1, 0));
        // Starvation: one load pending under 8 cycles of ALU traffic
        tbl.push_back(mk(0, 0, 0,        1, 20, 32'h200,  0, 13, 32'h103, 0, 1, 1, 0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1, 21, 32'h300 + i, 0, 0, 0,
                             1, 21, 32'h300 + i, (i == 7), 1, 1, 0));
        end
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 20, 32'h200, 0, 0, 1, 0));
        // Refill to force a stall, then violate it
        tbl.push_back(mk(1, 1, 32'h50,   1, 15, 32'h400,  1, 1, 32'h50,   0, 1, 1, 0));
        tbl.push_back(mk(1, 2, 32'h51,   1, 16, 32'h401,  1, 2, 32'h51,   0, 2, 1, 0));
        tbl.push_back(mk(1, 3, 32'h52,   1, 17, 32'h402,  1, 3, 32'h52,   0, 3, 1, 0));
        tbl.push_back(mk(1, 4, 32'h53,   1, 18, 32'h403,  1, 4, 32'h53,   1, 4, 0, 0));
        tbl.push_back(mk(1, 6, 32'h66,   0, 0, 0,         1, 6, 32'h66,   1, 4, 0, 1));
        tbl.push_back(mk(0, 0, 0,        0, 0, 0,         1, 15, 32'h400, 1, 3, 1, 1));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].aw, tbl[i].ad, tbl[i].mv, tbl[i].mw, tbl[i].md);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].rfw, tbl[i].wa, tbl[i].d,
                  tbl[i].st, tbl[i].cnt, tbl[i].rdy, tbl[i].perr);
        end

        // Asynchronous reset with 3 entries queued, mid-cycle
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", i), 0, 0, 0, 0, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
